// File: rtl/cpu_trace_mon.sv
// cpu_trace_mon: fetch/fault counters, PC watchpoints and a pre/post-trigger
// trace ring of {lpc, ir} samples drained oldest-first over rd_valid/rd_ready.
//
// Ports:
//   clk, reset_n      core clock, async active-low reset
//   fetch, lpc, ir    fetch strobe and the fetched PC / instruction
//   watch_pc/en       NWATCH watchpoints; channel k at [k*PC_W +: PC_W]
//   arm, post_cnt     restart capture; samples kept after the trigger
//   clr_cnt           clear cycles / faults / fault_trip
//   cycles, faults    fetch count, fault count (saturates at 255)
//   fault_trip        sticky fault watchdog flag
//   trig_hit/idx      sticky trigger flag; channel, or 7 for fault trigger
//   done              capture complete
//   rd_valid/data/rdy host drain port, one word per two clocks at most
//
// Optional build macro TRACE_TIMESTAMP_EN: each entry also stores
// cycles[15:0] at the fetch, appended as the rd_data LSBs.

module cpu_trace_mon #(
  parameter int             PC_W        = 14,
  parameter int             IR_W        = 49,
  parameter int             DEPTH       = 64,
  parameter int             NWATCH      = 4,
  parameter logic [PC_W-1:0] FAULT_PC   = 14'o26,
  parameter int             FAULT_LIMIT = 5,
  parameter int             CNT_W       = 32
`ifdef TRACE_TIMESTAMP_EN
  ,
  parameter int             DW          = PC_W + IR_W + 16
`else
  ,
  parameter int             DW          = PC_W + IR_W
`endif
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       fetch,
  input  logic [PC_W-1:0]            lpc,
  input  logic [IR_W-1:0]            ir,
  input  logic [NWATCH*PC_W-1:0]     watch_pc,
  input  logic [NWATCH-1:0]          watch_en,
  input  logic                       arm,
  input  logic [$clog2(DEPTH)-1:0]   post_cnt,
  input  logic                       clr_cnt,
  output logic [CNT_W-1:0]           cycles,
  output logic [7:0]                 faults,
  output logic                       fault_trip,
  output logic                       trig_hit,
  output logic [2:0]                 trig_idx,
  output logic                       done,
  output logic                       rd_valid,
  output logic [DW-1:0]              rd_data,
  input  logic                       rd_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, PRE, POST, DONE, READ
  } state_t;

  state_t          state;
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [AW:0]     fill;
  logic [AW-1:0]   remaining;

  logic [DW-1:0]   mem [DEPTH];
  logic [DW-1:0]   rd_q;
  logic [DW-1:0]   wdata;

  logic            f_fetch;
  logic            f_trig;
  logic            hit_any;
  logic [2:0]      hit_idx;
  logic            trig;
  logic [2:0]      tidx;
  logic            wr_en;
  logic            rd_load;

  // ---------------- counters ----------------
  assign f_fetch = fetch & (lpc == FAULT_PC);

  // The fault fetch that pushes the count past the limit; fault_trip
  // itself follows one cycle later.
  assign f_trig = f_fetch & ~clr_cnt & ~fault_trip
                & (faults == 8'(FAULT_LIMIT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycles     <= '0;
      faults     <= '0;
      fault_trip <= 1'b0;
    end else if (clr_cnt) begin
      cycles     <= '0;
      faults     <= '0;
      fault_trip <= 1'b0;
    end else begin
      if (fetch)
        cycles <= cycles + CNT_W'(1);
      if (f_fetch && faults != 8'hff)
        faults <= faults + 8'd1;
      if (faults > 8'(FAULT_LIMIT))
        fault_trip <= 1'b1;
    end
  end

  // ---------------- watch match ----------------
  // Scan high to low so the lowest enabled channel is left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int k = NWATCH - 1; k >= 0; k--) begin
      if (fetch && watch_en[k]
          && lpc == watch_pc[k*PC_W +: PC_W]) begin
        hit_any = 1'b1;
        hit_idx = 3'(k);
      end
    end
  end

  assign trig = hit_any | f_trig;
  assign tidx = hit_any ? hit_idx : 3'd7;

`ifdef TRACE_TIMESTAMP_EN
  assign wdata = {lpc, ir, cycles[15:0]};
`else
  assign wdata = {lpc, ir};
`endif

  assign wr_en   = fetch & ~arm & (state == PRE || state == POST);
  assign rd_load = (state == READ) & ~rd_valid;

  // ---------------- ring memory ----------------
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wptr] <= wdata;
    if (rd_load)
      rd_q <= mem[rptr];
  end

  assign rd_data = rd_valid ? rd_q : '0;

  // ---------------- capture / read FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wptr      <= '0;
      rptr      <= '0;
      fill      <= '0;
      remaining <= '0;
      trig_hit  <= 1'b0;
      trig_idx  <= '0;
      done      <= 1'b0;
      rd_valid  <= 1'b0;
    end else if (arm) begin
      state    <= PRE;
      wptr     <= '0;
      fill     <= '0;
      trig_hit <= 1'b0;
      trig_idx <= '0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        PRE: begin
          if (fetch) begin
            wptr <= wptr + AW'(1);
            if (fill != FULL)
              fill <= fill + (AW+1)'(1);
            if (trig) begin
              trig_hit  <= 1'b1;
              trig_idx  <= tidx;
              remaining <= post_cnt;
              if (post_cnt == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= POST;
              end
            end
          end
        end
        POST: begin
          if (fetch) begin
            wptr      <= wptr + AW'(1);
            remaining <= remaining - AW'(1);
            if (fill != FULL)
              fill <= fill + (AW+1)'(1);
            if (remaining == AW'(1)) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          // Oldest entry; wraps to wptr itself when the ring is full.
          rptr  <= wptr - fill[AW-1:0];
          state <= READ;
        end
        READ: begin
          // rd_valid drops after each pop so rd_q can reload from rptr.
          if (rd_valid) begin
            if (rd_ready) begin
              rptr     <= rptr + AW'(1);
              fill     <= fill - (AW+1)'(1);
              rd_valid <= 1'b0;
            end
          end else begin
            rd_valid <= (fill != '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_trace_mon.sv
// tb_cpu_trace_mon: directed tests against a queue-based reference model
// of cpu_trace_mon, checked every cycle on the falling clock edge.

module tb_cpu_trace_mon;

  localparam int PC_W   = 14;
  localparam int IR_W   = 49;
  localparam int DEPTH  = 64;
  localparam int NWATCH = 4;
  localparam int LIMIT  = 5;
  localparam logic [PC_W-1:0] FPC = 14'o26;
`ifdef TRACE_TIMESTAMP_EN
  localparam int DW = PC_W + IR_W + 16;
`else
  localparam int DW = PC_W + IR_W;
`endif

  typedef logic [DW-1:0] word_t;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   fetch = 1'b0;
  logic [PC_W-1:0]        lpc = '0;
  logic [IR_W-1:0]        ir = '0;
  logic [NWATCH*PC_W-1:0] watch_pc = '0;
  logic [NWATCH-1:0]      watch_en = '0;
  logic                   arm = 1'b0;
  logic [5:0]             post_cnt = '0;
  logic                   clr_cnt = 1'b0;
  logic [31:0]            cycles;
  logic [7:0]             faults;
  logic                   fault_trip;
  logic                   trig_hit;
  logic [2:0]             trig_idx;
  logic                   done;
  logic                   rd_valid;
  word_t                  rd_data;
  logic                   rd_ready = 1'b0;

  cpu_trace_mon dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fetch      (fetch),
    .lpc        (lpc),
    .ir         (ir),
    .watch_pc   (watch_pc),
    .watch_en   (watch_en),
    .arm        (arm),
    .post_cnt   (post_cnt),
    .clr_cnt    (clr_cnt),
    .cycles     (cycles),
    .faults     (faults),
    .fault_trip (fault_trip),
    .trig_hit   (trig_hit),
    .trig_idx   (trig_idx),
    .done       (done),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_ready   (rd_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_pop = 0;
  word_t got[$];

  task automatic check(input string nm, input logic [127:0] a,
                       input logic [127:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 pre-trigger, 2 post-trigger, 3 capture finished
  logic [31:0] m_cyc = '0;
  int          m_flt = 0;
  bit          m_trip = 0;
  bit          m_hit = 0;
  bit          m_done = 0;
  logic [2:0]  m_idx = '0;
  int          m_mode = 0;
  int          m_rem = 0;
  word_t       m_ring[$];

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_cyc = '0; m_flt = 0; m_trip = 0;
      m_hit = 0; m_done = 0; m_mode = 0;
      m_ring.delete();
    end else begin
      word_t s;
      int w;
      bit ft;
`ifdef TRACE_TIMESTAMP_EN
      s = {lpc, ir, m_cyc[15:0]};
`else
      s = {lpc, ir};
`endif
      ft = fetch && lpc == FPC && !clr_cnt && !m_trip && m_flt == LIMIT;
      w = -1;
      for (int k = NWATCH - 1; k >= 0; k--)
        if (fetch && watch_en[k] && lpc == watch_pc[k*PC_W +: PC_W])
          w = k;
      if (clr_cnt) begin
        m_cyc = '0; m_flt = 0; m_trip = 0;
      end else begin
        if (m_flt > LIMIT) m_trip = 1;
        if (fetch) m_cyc = m_cyc + 1;
        if (fetch && lpc == FPC && m_flt < 255) m_flt++;
      end
      if (arm) begin
        m_mode = 1; m_hit = 0; m_done = 0;
        m_ring.delete();
      end else if (fetch && (m_mode == 1 || m_mode == 2)) begin
        m_ring.push_back(s);
        if (m_ring.size() > DEPTH) void'(m_ring.pop_front());
        if (m_mode == 1 && (w >= 0 || ft)) begin
          m_hit = 1;
          m_idx = (w >= 0) ? 3'(w) : 3'd7;
          if (post_cnt == 0) begin
            m_mode = 3; m_done = 1;
          end else begin
            m_mode = 2; m_rem = int'(post_cnt);
          end
        end else if (m_mode == 2) begin
          m_rem--;
          if (m_rem == 0) begin
            m_mode = 3; m_done = 1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit    hold = 0;
  word_t hold_data = '0;

  initial forever begin
    @(negedge clk);
    check("cycles", cycles, m_cyc);
    check("faults", faults, 8'(m_flt));
    check("fault_trip", fault_trip, m_trip);
    check("trig_hit", trig_hit, m_hit);
    check("done", done, m_done);
    if (m_hit) check("trig_idx", trig_idx, m_idx);
    if (hold) check("rd_hold", {rd_valid, rd_data}, {1'b1, hold_data});
    check("rd_valid_ok",
          rd_valid && !(m_done && m_ring.size() > 0), 0);
    if (rd_valid && rd_ready && m_ring.size() > 0) begin
      check("rd_data", rd_data, m_ring[0]);
      void'(m_ring.pop_front());
      got.push_back(rd_data);
      n_pop++;
    end
    hold = rd_valid && !rd_ready;
    hold_data = rd_data;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fetch1(input logic [PC_W-1:0] pc, input int i);
    @(posedge clk); #1;
    fetch = 1'b1; lpc = pc; ir = 49'(i * 7919 + 13);
    @(posedge clk); #1;
    fetch = 1'b0;
  endtask

  task automatic pulse_arm();
    @(posedge clk); #1 arm = 1'b1;
    @(posedge clk); #1 arm = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr_cnt = 1'b1;
    @(posedge clk); #1 clr_cnt = 1'b0;
  endtask

  task automatic drain(input int n, input int stall, input bit tog);
    int start;
    int budget;
    start = n_pop;
    budget = 0;
    got.delete();
    rd_ready = 1'b0;
    step(stall);
    rd_ready = 1'b1;
    while (n_pop < start + n && budget < 600) begin
      @(posedge clk); #1;
      if (tog) rd_ready = ~rd_ready;
      budget++;
    end
    rd_ready = 1'b0;
    check("drain_count", n_pop - start, n);
    step(4);
  endtask

  function automatic logic [PC_W-1:0] pc_of(input word_t wd);
    return wd[DW-1 -: PC_W];
  endfunction

  initial begin
    // reset state
    step(3);
    check("rst_cycles", cycles, 0);
    check("rst_faults", faults, 0);
    check("rst_trip", fault_trip, 0);
    check("rst_done", done, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    reset_n = 1'b1;
    step(2);

    // async reset mid-capture
    post_cnt = 6'd3;
    pulse_arm();
    for (int i = 1; i <= 10; i++) fetch1(14'(100 + i), i);
    check("pre_rst_cycles", cycles, 10);
    @(posedge clk); #3 reset_n = 1'b0;
    #1;
    check("arst_cycles", cycles, 0);
    check("arst_trig_hit", trig_hit, 0);
    check("arst_done", done, 0);
    check("arst_rd_valid", rd_valid, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    step(2);

    // fault watchdog with fault trigger
    pulse_clr();
    post_cnt = 6'd0;
    pulse_arm();
    for (int i = 1; i <= 6; i++) fetch1(FPC, i);
    step(3);
    check("flt_faults", faults, 6);
    check("flt_trip", fault_trip, 1);
    check("flt_idx", trig_idx, 7);
    check("flt_cycles", cycles, 6);
    drain(6, 0, 0);
    pulse_clr();
    step(1);
    check("clr_faults", faults, 0);
    check("clr_trip", fault_trip, 0);

    // watch trigger with post-trigger samples and backpressure
    watch_pc = '0;
    watch_pc[2*PC_W +: PC_W] = 14'o1000;
    watch_en = 4'b0100;
    post_cnt = 6'd3;
    pulse_arm();
    for (int i = 1; i <= 20; i++)
      fetch1((i == 10) ? 14'o1000 : 14'(i), i);
    step(2);
    check("w_idx", trig_idx, 2);
    check("w_done", done, 1);
    drain(13, 20, 1);
    check("w_nwords", got.size(), 13);
    if (got.size() == 13) begin
      check("w_first", pc_of(got[0]), 1);
      check("w_trig", pc_of(got[9]), 14'o1000);
      check("w_last", pc_of(got[12]), 13);
    end

    // ring wrap: 100 samples then trigger, nothing after
    post_cnt = 6'd0;
    pulse_arm();
    for (int i = 1; i <= 100; i++) fetch1(14'(200 + i), i);
    fetch1(14'o1000, 101);
    step(2);
    drain(64, 0, 0);
    check("wrap_nwords", got.size(), 64);
    if (got.size() == 64) begin
      check("wrap_first", pc_of(got[0]), 238);
      check("wrap_last", pc_of(got[63]), 14'o1000);
    end

    // priority: watch channels 1 and 3 on the tripping fault fetch
    pulse_clr();
    watch_en = '0;
    watch_pc = '0;
    watch_pc[1*PC_W +: PC_W] = FPC;
    watch_pc[3*PC_W +: PC_W] = FPC;
    pulse_arm();
    for (int i = 1; i <= 5; i++) fetch1(FPC, i);
    check("pri_nohit", trig_hit, 0);
    watch_en = 4'b1010;
    fetch1(FPC, 6);
    step(3);
    check("pri_idx", trig_idx, 1);
    check("pri_trip", fault_trip, 1);
    watch_en = '0;
    step(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
